// File: rtl/data_frame_pkg.sv
// -----------------------------------------------------------------------------
// data_frame_pkg
//   Shared definitions for the 64-bit trigger-channel data frame. The frame
//   generator and the frame parser both import this package so that the word
//   layout is defined in exactly one place.
//
//   Header word : [63:56] HEADER_ID, [55:48] channel ID, [47:40] data length,
//                 [39:32] reserved (0), [31:0] first timestamp
//   Footer word : [63:56] FOOTER_ID, [55:8] timestamp, [7:0] data word count
// -----------------------------------------------------------------------------
package data_frame_pkg;

  // Marker bytes in the top byte of header and footer words
  localparam logic [7:0] HEADER_ID = 8'hAA;
  localparam logic [7:0] FOOTER_ID = 8'h55;

  // Field bit positions (LSB of each field) and widths
  localparam int ID_LSB       = 56;
  localparam int HDR_CH_LSB   = 48;
  localparam int HDR_LEN_LSB  = 40;
  localparam int HDR_RSVD_LSB = 32;
  localparam int HDR_TS_LSB   = 0;
  localparam int HDR_TS_BITS  = 32;
  localparam int FTR_TS_LSB   = 8;
  localparam int FTR_TS_BITS  = 48;
  localparam int FTR_CNT_LSB  = 0;

  // Frame position of the next expected word
  typedef enum logic [1:0] {
    HEADER = 2'd0,
    DATA   = 2'd1,
    FOOTER = 2'd2
  } frameStateT;

  // Packed views of the two framing words, MSB first
  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  chId;
    logic [7:0]  len;
    logic [7:0]  rsvd;
    logic [31:0] ts;
  } headerT;

  typedef struct packed {
    logic [7:0]  id;
    logic [47:0] ts;
    logic [7:0]  cnt;
  } footerT;

  // Word builders for the generator side
  function automatic logic [63:0] packHeader(input logic [7:0]  chId,
                                             input logic [7:0]  len,
                                             input logic [31:0] ts);
    headerT h;
    h.id   = HEADER_ID;
    h.chId = chId;
    h.len  = len;
    h.rsvd = 8'h00;
    h.ts   = ts;
    return h;
  endfunction

  function automatic logic [63:0] packFooter(input logic [47:0] ts,
                                             input logic [7:0]  cnt);
    footerT f;
    f.id  = FOOTER_ID;
    f.ts  = ts;
    f.cnt = cnt;
    return f;
  endfunction

endpackage

// File: rtl/data_frame_parser_frame_out_reg.sv
// -----------------------------------------------------------------------------
// frame_out_reg
//   One-deep output register with valid/ready handshake and a last-word flag.
//   It can be drained and reloaded in the same cycle, which gives full
//   throughput while downstream keeps its ready high.
//
// Ports
//   CLK, RESETN  clock, asynchronous active-low reset
//   load         write loadData/loadLast into the register (caller guarantees
//                canLoad is high when load is asserted)
//   loadData     word to store
//   loadLast     last-word flag to store
//   drainReady   downstream ready
//   canLoad      register is empty or is being drained this cycle
//   valid        register holds a word
//   data, last   stored word and its last flag
// -----------------------------------------------------------------------------
module frame_out_reg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  input  logic             loadLast,
  input  logic             drainReady,
  output logic             canLoad,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  logic             validReg;
  logic             lastReg;
  logic [WIDTH-1:0] dataReg;

  // Combinational from drainReady so a drain and a load can share one cycle
  assign canLoad = ~validReg | drainReady;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      validReg <= 1'b0;
      lastReg  <= 1'b0;
      dataReg  <= '0;
    end else if (load) begin
      validReg <= 1'b1;
      lastReg  <= loadLast;
      dataReg  <= loadData;
    end else if (drainReady) begin
      // Word leaves; data is kept as-is, only the qualifiers drop
      validReg <= 1'b0;
      lastReg  <= 1'b0;
    end
  end

  assign valid = validReg;
  assign data  = dataReg;
  assign last  = lastReg;

endmodule

// File: rtl/data_frame_parser.sv
// -----------------------------------------------------------------------------
// data_frame_parser
//   Receiving end of the 64-bit trigger-channel data frame stream. Header and
//   footer words are checked and absorbed; only data words are forwarded, with
//   a last-word marker. Header/footer fields are latched for downstream use and
//   good-frame / error counters are kept for status readout.
//
// Ports
//   CLK, RESETN        clock, asynchronous active-low reset
//   iVALID, oREADY, DIN  input word stream (valid/ready)
//   oVALID, iREADY, DOUT, oLAST  data word output stream (valid/ready)
//   FRAME_CH_ID, FRAME_LEN, FRAME_TS  fields of the last good header
//   FOOTER_TS          timestamp of the last footer
//   FRAME_DONE         one-cycle pulse after a good footer
//   FRAME_ERR          one-cycle pulse after a bad header or bad footer
//   FRAME_CNT, ERR_CNT saturating good-frame and error counters
// -----------------------------------------------------------------------------
module data_frame_parser
  import data_frame_pkg::*;
#(
  parameter int unsigned CHANNEL_ID             = 0,
  parameter int unsigned MAX_FRAME_LENGTH       = 200,
  parameter int unsigned FIRST_TIME_STAMP_WIDTH = 32,
  parameter int unsigned TIME_STAMP_WIDTH       = 48,
  parameter int unsigned DIN_WIDTH              = 64,
  parameter int unsigned CNT_WIDTH              = 16
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  input  logic                              iVALID,
  output logic                              oREADY,
  input  logic [DIN_WIDTH-1:0]              DIN,
  input  logic                              iREADY,
  output logic                              oVALID,
  output logic [DIN_WIDTH-1:0]              DOUT,
  output logic                              oLAST,
  output logic [7:0]                        FRAME_CH_ID,
  output logic [7:0]                        FRAME_LEN,
  output logic [FIRST_TIME_STAMP_WIDTH-1:0] FRAME_TS,
  output logic [TIME_STAMP_WIDTH-1:0]       FOOTER_TS,
  output logic                              FRAME_DONE,
  output logic                              FRAME_ERR,
  output logic [CNT_WIDTH-1:0]              FRAME_CNT,
  output logic [CNT_WIDTH-1:0]              ERR_CNT
);

  localparam logic [7:0]           CH_ID8   = 8'(CHANNEL_ID);
  localparam logic [7:0]           MAX_LEN8 = 8'(MAX_FRAME_LENGTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Field decode of the incoming word (header and footer share the ID byte)
  // ---------------------------------------------------------------------------
  logic [7:0] wordId;
  logic [7:0] hdrChId;
  logic [7:0] hdrLen;
  logic [7:0] ftrCnt;
  logic       hdrGood;
  logic       ftrGood;

  assign wordId  = DIN[ID_LSB +: 8];
  assign hdrChId = DIN[HDR_CH_LSB +: 8];
  assign hdrLen  = DIN[HDR_LEN_LSB +: 8];
  assign ftrCnt  = DIN[FTR_CNT_LSB +: 8];

  // ---------------------------------------------------------------------------
  // State and latched fields
  // ---------------------------------------------------------------------------
  frameStateT                        stateReg;
  frameStateT                        stateNext;
  logic [7:0]                        wordCntReg;
  logic [7:0]                        wordCntNext;
  logic [7:0]                        wordCntInc;
  logic [7:0]                        frameChIdReg;
  logic [7:0]                        frameLenReg;
  logic [FIRST_TIME_STAMP_WIDTH-1:0] frameTsReg;
  logic [TIME_STAMP_WIDTH-1:0]       footerTsReg;
  logic                              doneReg;
  logic                              doneNext;
  logic                              errReg;
  logic                              errNext;
  logic [CNT_WIDTH-1:0]              frameCntReg;
  logic [CNT_WIDTH-1:0]              errCntReg;
  logic                              latchHeader;
  logic                              latchFooter;

  // Reserved header bits are not checked; only ID, channel and length qualify
  assign hdrGood = (wordId == HEADER_ID) && (hdrChId == CH_ID8) &&
                   (hdrLen != 8'd0) && (hdrLen <= MAX_LEN8);
  assign ftrGood = (wordId == FOOTER_ID) && (ftrCnt == frameLenReg);

  // ---------------------------------------------------------------------------
  // Handshake: every word (header, data, footer) waits for room in the output
  // register, so input ready is the same in all states.
  // ---------------------------------------------------------------------------
  logic outCanLoad;
  logic accept;
  logic dataLoad;
  logic dataLast;

  assign oREADY     = outCanLoad;
  assign accept     = iVALID & outCanLoad;
  assign wordCntInc = wordCntReg + 8'd1;
  assign dataLoad   = accept && (stateReg == DATA);
  assign dataLast   = (wordCntInc == frameLenReg);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext   = stateReg;
    wordCntNext = wordCntReg;
    latchHeader = 1'b0;
    latchFooter = 1'b0;
    doneNext    = 1'b0;
    errNext     = 1'b0;
    if (accept) begin
      case (stateReg)
        HEADER: begin
          // A rejected word is dropped; the next word is again a header candidate
          if (hdrGood) begin
            latchHeader = 1'b1;
            wordCntNext = 8'd0;
            stateNext   = DATA;
          end else begin
            errNext = 1'b1;
          end
        end
        DATA: begin
          wordCntNext = wordCntInc;
          if (dataLast) begin
            stateNext = FOOTER;
          end
        end
        FOOTER: begin
          // Footer timestamp is captured even when the footer itself is bad
          latchFooter = 1'b1;
          stateNext   = HEADER;
          if (ftrGood) begin
            doneNext = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
        default: begin
          stateNext = HEADER;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, word counter and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      stateReg   <= HEADER;
      wordCntReg <= 8'd0;
      doneReg    <= 1'b0;
      errReg     <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      wordCntReg <= wordCntNext;
      doneReg    <= doneNext;
      errReg     <= errNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched header/footer fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      frameChIdReg <= 8'd0;
      frameLenReg  <= 8'd0;
      frameTsReg   <= '0;
    end else if (latchHeader) begin
      frameChIdReg <= hdrChId;
      frameLenReg  <= hdrLen;
      frameTsReg   <= DIN[HDR_TS_LSB +: FIRST_TIME_STAMP_WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      footerTsReg <= '0;
    end else if (latchFooter) begin
      footerTsReg <= DIN[FTR_TS_LSB +: TIME_STAMP_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating status counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      frameCntReg <= '0;
    end else if (doneNext && !(&frameCntReg)) begin
      frameCntReg <= frameCntReg + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      errCntReg <= '0;
    end else if (errNext && !(&errCntReg)) begin
      errCntReg <= errCntReg + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register for forwarded data words
  // ---------------------------------------------------------------------------
  frame_out_reg #(
    .WIDTH(DIN_WIDTH)
  ) uOutReg (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .load       (dataLoad),
    .loadData   (DIN),
    .loadLast   (dataLast),
    .drainReady (iREADY),
    .canLoad    (outCanLoad),
    .valid      (oVALID),
    .data       (DOUT),
    .last       (oLAST)
  );

  assign FRAME_CH_ID = frameChIdReg;
  assign FRAME_LEN   = frameLenReg;
  assign FRAME_TS    = frameTsReg;
  assign FOOTER_TS   = footerTsReg;
  assign FRAME_DONE  = doneReg;
  assign FRAME_ERR   = errReg;
  assign FRAME_CNT   = frameCntReg;
  assign ERR_CNT     = errCntReg;

endmodule
